// File: rtl/nnrv_uart_tx.sv
// Memory-mapped UART transmitter with a small byte FIFO and an 8N1 serial FSM.
// Register map: 0x0 TXDATA (write-only), 0x4 STATUS (read), 0x8 LED (read/write).
//
// state | meaning
// IDLE  | line high, pop FIFO head into shift register when data is waiting
// START | start bit, line low for CLK_DIV cycles
// DATA  | 8 data bits LSB first, CLK_DIV cycles each
// STOP  | stop bit, line high for CLK_DIV cycles
module nnrv_uart_tx #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr_en,
   input  logic        i_rd_en,
   input  logic [3:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_tx,
   output logic        o_led,
   output logic        o_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [7:0]    shift;
   logic [7:0]    baud_cnt;
   logic [2:0]    bit_cnt;
   logic          overflow;

   logic sel_txdata, sel_status, sel_led;
   logic full, empty, push, drop, pop, baud_done, tx_next;
   logic unused_wdata;

   assign sel_txdata = (i_addr == 4'h0);
   assign sel_status = (i_addr == 4'h4);
   assign sel_led    = (i_addr == 4'h8);

   // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a write.
   assign full      = (count == DEPTH);
   assign empty     = (count == '0);
   assign push      = i_wr_en && sel_txdata && !full;
   assign drop      = i_wr_en && sel_txdata && full;
   assign pop       = (state == IDLE) && !empty;
   assign baud_done = (baud_cnt == DIV_LAST);
   assign o_busy    = !empty || (state != IDLE);

   assign unused_wdata = ^i_wdata[31:8];

   always_comb begin
      tx_next = 1'b1;
      case (state)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= i_wdata[7:0];
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // o_tx follows the state one edge late, which gives the two-edge write-to-start latency.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         o_tx     <= 1'b1;
         shift    <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         o_tx <= tx_next;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (!empty) begin
                  shift <= fifo_mem[rd_ptr];
                  state <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A dropped push outranks a STATUS read so the overflow event is never lost.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_led    <= 1'b0;
         o_rdata  <= '0;
         overflow <= 1'b0;
      end else begin
         if (i_wr_en && sel_led) begin
            o_led <= i_wdata[0];
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (i_rd_en && sel_status) begin
            overflow <= 1'b0;
         end
         if (i_rd_en) begin
            if (sel_status) begin
               o_rdata <= {28'b0, overflow, full, empty, o_busy};
            end else if (sel_led) begin
               o_rdata <= {31'b0, o_led};
            end else begin
               o_rdata <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_nnrv_uart_tx.sv
// Directed bench for nnrv_uart_tx: a line monitor decodes frames and checks them
// against a queue of bytes expected at write time.
module tb_nnrv_uart_tx;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [3:0]  addr  = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        tx;
   logic        led;
   logic        busy;

   always #5 clk = ~clk;

   nnrv_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_wr_en(wr_en),
      .i_rd_en(rd_en),
      .i_addr (addr),
      .i_wdata(wdata),
      .o_rdata(rdata),
      .o_tx   (tx),
      .o_led  (led),
      .o_busy (busy)
   );

   int         tests  = 0;
   int         fails  = 0;
   int         cyc    = 0;
   int         rx_cnt = 0;
   logic [7:0] exp_q[$];
   int         starts[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic read(input logic [3:0] a, input logic [31:0] exp, input string tag);
      rd_en = 1'b1;
      addr  = a;
      @(negedge clk);
      rd_en = 1'b0;
      check(tag, rdata, exp);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'b0, busy}, 32'd0);
      repeat (4) @(negedge clk);
   endtask

   // Line monitor: start sampled at offset 2, data bits mid-cell, stop at offset 38.
   logic       prev_tx = 1'b1;
   logic [7:0] rx_byte;
   logic       start_ok, stop_ok, aborted;
   int         start_cyc;

   initial begin
      forever begin
         @(negedge clk);
         if (rst !== 1'b1 && prev_tx === 1'b1 && tx === 1'b0) begin
            start_cyc = cyc;
            aborted   = 1'b0;
            start_ok  = 1'b0;
            stop_ok   = 1'b0;
            rx_byte   = 8'h0;
            for (int k = 1; k <= 38; k++) begin
               @(negedge clk);
               if (rst === 1'b1) aborted = 1'b1;
               if (k == 2) start_ok = (tx === 1'b0);
               if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) rx_byte[(k - 6) / 4] = tx;
               if (k == 38) stop_ok = (tx === 1'b1);
            end
            if (!aborted) begin
               rx_cnt++;
               starts.push_back(start_cyc);
               if (exp_q.size() == 0) begin
                  check("rx_unexpected_frame", 32'd0, 32'd1);
               end else begin
                  check("rx_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
                  check("rx_framing", {30'b0, start_ok, stop_ok}, 32'd3);
               end
            end
         end
         prev_tx = tx;
      end
   end

   logic low_seen;

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'b0, tx}, 32'd1);
      check("reset_led", {31'b0, led}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single frame: latency and busy timing
      exp_q.push_back(8'h55);
      write(4'h0, 32'h55);
      check("tx_high_after_push", {31'b0, tx}, 32'd1);
      @(negedge clk);
      check("tx_high_at_pop", {31'b0, tx}, 32'd1);
      @(negedge clk);
      check("tx_start_low", {31'b0, tx}, 32'd0);
      repeat (38) @(negedge clk);
      check("busy_in_stop", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check("busy_after_stop", {31'b0, busy}, 32'd0);
      repeat (4) @(negedge clk);
      check("rx_count_single", rx_cnt, 32'd1);

      // Back-to-back frames
      starts.delete();
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hB2);
      exp_q.push_back(8'hC3);
      write(4'h0, 32'hA1);
      write(4'h0, 32'hB2);
      write(4'h0, 32'hC3);
      wait_idle(400, "idle_after_burst");
      check("rx_count_burst", rx_cnt, 32'd4);
      check("burst_frames", starts.size(), 32'd3);
      for (int i = 1; i < starts.size(); i++)
         check("frame_spacing", 32'(starts[i] - starts[i-1]), 32'(10 * CLK_DIV + 1));

      // Overflow: six writes into a depth-4 FIFO, one byte already popped
      for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h11 + i));
      for (int i = 0; i < 6; i++) write(4'h0, 32'(32'h11 + i));
      repeat (50) @(negedge clk);
      read(4'h4, 32'h9, "status_overflow");
      wait_idle(600, "idle_after_overflow");
      read(4'h4, 32'h2, "status_after_drain");
      @(negedge clk);
      check("rdata_hold", rdata, 32'h2);
      check("rx_count_overflow", rx_cnt, 32'd9);
      check("queue_drained", exp_q.size(), 32'd0);

      // LED register
      write(4'h8, 32'h1);
      check("led_set", {31'b0, led}, 32'd1);
      read(4'h8, 32'h1, "led_read_1");
      write(4'h8, 32'hFFFF_FFFE);
      check("led_clear", {31'b0, led}, 32'd0);
      read(4'h8, 32'h0, "led_read_0");

      // Reserved and read-only offsets
      write(4'hC, 32'hFF);
      write(4'h4, 32'hF);
      check("reserved_wr_led", {31'b0, led}, 32'd0);
      check("reserved_wr_busy", {31'b0, busy}, 32'd0);
      read(4'hC, 32'h0, "reserved_read");
      read(4'h4, 32'h2, "status_after_wr");
      read(4'h0, 32'h0, "txdata_read");

      // Reset during data bit 3 of 0x08 (only bit 3 set)
      write(4'h0, 32'h08);
      repeat (17) @(negedge clk);
      check("tx_bit2", {31'b0, tx}, 32'd0);
      @(negedge clk);
      check("tx_bit3", {31'b0, tx}, 32'd1);
      rst   = 1'b1;
      wr_en = 1'b1;
      addr  = 4'h8;
      wdata = 32'h1;
      @(negedge clk);
      check("rst_mid_tx", {31'b0, tx}, 32'd1);
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_led", {31'b0, led}, 32'd0);
      @(negedge clk);
      wr_en = 1'b0;
      rst   = 1'b0;
      read(4'h4, 32'h2, "status_after_reset");
      low_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) low_seen = 1'b1;
      end
      check("no_bits_after_reset", {31'b0, low_seen}, 32'd0);
      check("rx_count_after_reset", rx_cnt, 32'd9);

      // Recovery after reset
      exp_q.push_back(8'h5A);
      write(4'h0, 32'h5A);
      wait_idle(200, "idle_after_recovery");
      check("rx_count_recovery", rx_cnt, 32'd10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
